// File: rtl/next_pc_unit_if.sv
// Fetch-redirect bus between the pipeline and the next-PC unit.
// master: pipeline side (drives IF/MEM inputs); slave: next_pc_unit.
interface next_pc_unit_if;
  logic        stall_IF;
  logic        predict_taken;
  logic        is_branch_MEM;
  logic        actual_taken_MEM;
  logic [31:0] pc_MEM;
  logic [31:0] branch_target_MEM;
  logic        pred_taken_MEM;
  logic [31:0] pred_target_MEM;
  logic [31:0] pc_IF;
  logic        pred_taken_IF;
  logic [31:0] pred_target_IF;
  logic        flush;
  logic [15:0] mispredict_cnt;
  logic [31:0] branch_cnt;

  modport master (
    output stall_IF, predict_taken, is_branch_MEM, actual_taken_MEM,
           pc_MEM, branch_target_MEM, pred_taken_MEM, pred_target_MEM,
    input  pc_IF, pred_taken_IF, pred_target_IF, flush,
           mispredict_cnt, branch_cnt
  );

  modport slave (
    input  stall_IF, predict_taken, is_branch_MEM, actual_taken_MEM,
           pc_MEM, branch_target_MEM, pred_taken_MEM, pred_target_MEM,
    output pc_IF, pred_taken_IF, pred_target_IF, flush,
           mispredict_cnt, branch_cnt
  );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC selection with a 16-entry direct-mapped BTB, MEM-stage
// mispredict recovery and branch/mispredict statistics counters.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input logic           clk,
  input logic           rst_n,
  next_pc_unit_if.slave bus
);

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [25:0]            btb_tag    [BTB_ENTRIES];
  logic [29:0]            btb_target [BTB_ENTRIES];

  logic [31:0] pc_q;
  logic [15:0] mispredict_cnt_q;
  logic [31:0] branch_cnt_q;

  logic [3:0]  rd_idx;
  logic [3:0]  wr_idx;
  logic        btb_hit;
  logic        btb_we;
  logic [31:0] pc_plus4;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [31:0] next_pc;

  // BTB lookup, prediction, mispredict detection and next-PC priority mux
  always_comb begin
    rd_idx      = pc_q[5:2];
    wr_idx      = bus.pc_MEM[5:2];
    btb_hit     = btb_valid[rd_idx] && (btb_tag[rd_idx] == pc_q[31:6]);
    pc_plus4    = pc_q + 32'd4;
    pred_taken  = bus.predict_taken && btb_hit;
    pred_target = btb_hit ? {btb_target[rd_idx], 2'b00} : pc_plus4;

    mispredict  = bus.is_branch_MEM &&
                  ((bus.actual_taken_MEM != bus.pred_taken_MEM) ||
                   (bus.actual_taken_MEM && bus.pred_taken_MEM &&
                    (bus.branch_target_MEM != bus.pred_target_MEM)));
    correct_pc  = bus.actual_taken_MEM ? {bus.branch_target_MEM[31:2], 2'b00}
                                       : bus.pc_MEM + 32'd4;
    btb_we      = bus.is_branch_MEM && bus.actual_taken_MEM;

    if (mispredict)        next_pc = correct_pc;
    else if (bus.stall_IF) next_pc = pc_q;
    else if (pred_taken)   next_pc = pred_target;
    else                   next_pc = pc_plus4;
  end

  // Fetch PC and statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      mispredict_cnt_q <= '0;
      branch_cnt_q     <= '0;
    end else begin
      pc_q <= next_pc;
      if (bus.is_branch_MEM)
        branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict && (mispredict_cnt_q != '1))
        mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
    end
  end

  // BTB valid bits: cleared by reset, set by any taken resolution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      btb_valid         <= '0;
    else if (btb_we) btb_valid[wr_idx] <= 1'b1;
  end

  // BTB payload: tag/target only matter once valid, so no reset needed
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[wr_idx]    <= bus.pc_MEM[31:6];
      btb_target[wr_idx] <= bus.branch_target_MEM[31:2];
    end
  end

  assign bus.pc_IF          = pc_q;
  assign bus.pred_taken_IF  = pred_taken;
  assign bus.pred_target_IF = pred_target;
  assign bus.flush          = mispredict;
  assign bus.mispredict_cnt = mispredict_cnt_q;
  assign bus.branch_cnt     = branch_cnt_q;

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, fetch address loaded at reset.
REQ-002 Parameter BTB_ENTRIES, 16, direct-mapped BTB depth; fixed at 16, index PC[5:2].
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall_IF  input  1  hold pc_IF; no fetch advance.
REQ-006 predict_taken  input  1  direction prediction from the 2-bit BHT for pc_IF.
REQ-007 is_branch_MEM  input  1  conditional branch resolved in MEM this cycle.
REQ-008 actual_taken_MEM  input  1  resolved branch direction.
REQ-009 pc_MEM  input  32  PC of the resolving branch.
REQ-010 branch_target_MEM  input  32  computed taken target.
REQ-011 pred_taken_MEM  input  1  prediction carried down the pipe with that branch.
REQ-012 pred_target_MEM  input  32  predicted target carried down the pipe.
REQ-013 pc_IF  output  32  current fetch address; also drives the BHT read index.
REQ-014 pred_taken_IF  output  1  final prediction to carry with the fetched instruction.
REQ-015 pred_target_IF  output  32  predicted target to carry with the fetched instruction.
REQ-016 flush  output  1  mispredict; IF/ID/EX contents are to be killed.
REQ-017 mispredict_cnt  output  16  saturating mispredict counter.
REQ-018 branch_cnt  output  32  wrapping resolved-branch counter.

Function
REQ-019 BTB entry fields: valid, tag = PC[31:6], target[31:2]; pc_IF index = pc_IF[5:2].
REQ-020 btb_hit = valid && tag match on pc_IF, combinational.
REQ-021 pred_taken_IF = predict_taken AND btb_hit; pred_target_IF = {entry target, 2'b00} on hit, else pc_IF+4.
REQ-022 Mispredict = is_branch_MEM AND (actual_taken_MEM != pred_taken_MEM OR (both 1 AND branch_target_MEM != pred_target_MEM)).
REQ-023 flush = mispredict, combinational, same cycle as the MEM inputs.
REQ-024 Correct PC = actual_taken_MEM ? {branch_target_MEM[31:2],2'b00} : pc_MEM+4 (32-bit wrap).
REQ-025 Next pc_IF priority: mispredict -> correct PC; else stall_IF -> hold; else pred_taken_IF -> pred_target_IF; else pc_IF+4.
REQ-026 Mispredict redirect overrides stall_IF; loaded on the next edge, single cycle.
REQ-027 is_branch_MEM AND actual_taken_MEM writes the entry at pc_MEM[5:2]: valid=1, tag=pc_MEM[31:6], target=branch_target_MEM[31:2], overwriting any prior entry.
REQ-028 Not-taken resolution leaves the BTB unchanged; no invalidation.
REQ-029 Same-index read and write in one cycle: the read returns the pre-write contents; the new entry is visible from the next cycle.
REQ-030 BTB writes are independent of stall_IF.
REQ-031 branch_cnt increments by 1 per is_branch_MEM cycle, wrapping from 0xFFFF_FFFF to 0.
REQ-032 mispredict_cnt increments per mispredict and saturates at 0xFFFF.
REQ-033 pc_IF is always word-aligned: bits[1:0] = 0.

Reset
REQ-034 rst_n low immediately sets: pc_IF = RESET_PC, all BTB valid = 0, both counters = 0.
REQ-035 While reset is asserted, outputs derive from reset state: pred_taken_IF=0, pred_target_IF=RESET_PC+4.
REQ-036 flush has no reset term and follows its inputs.
REQ-037 Reset mid-redirect discards the pending redirect.
REQ-038 First post-reset edge without stall gives pc_IF = RESET_PC+4.

Verification
REQ-039 Reset release, no branches, no stall, 3 edges -> pc_IF 0x0, 0x4, 0x8, 0xC.
REQ-040 Branch at 0x40 resolves taken (pred 0) to 0x100 -> flush=1 that cycle, pc_IF=0x100 next edge, BTB[0] holds tag 0x1 / target 0x100, mispredict_cnt=1.
REQ-041 pc_IF=0x40 after REQ-040 with predict_taken=1 -> pred_taken_IF=1, next pc_IF=0x100; with predict_taken=0 -> next pc_IF=0x44.
REQ-042 Aliasing: pc_IF=0x80 (index 0, tag 0x2) with predict_taken=1 -> btb_hit=0, next pc_IF=0x84.
REQ-043 stall_IF=1 with a simultaneous mispredict (pred 1, actual 0, pc_MEM=0x200) -> pc_IF=0x204 next edge.
REQ-044 mispredict_cnt preset to 0xFFFF (via 65535 mispredicts), one more mispredict -> stays 0xFFFF; branch_cnt still increments.
